uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares the single UART transmitter between NUM_REQ requesters
//  (e.g. register-file read responses, ALU results). Grants one requester per frame and sends
//  its 1- or 2-byte frame as a sequence of single-byte TX_P_DATA/TX_D_VLD transfers.
//  Each byte completes only when the transmitter's Busy has gone high and then low again.
//  Sits between the system controller and the UART_TOP TX side.
// PARAMETERS
//  WIDTH    8    UART data byte width
//  NUM_REQ  4    number of requesters (>=2); ID_W = $clog2(NUM_REQ)
//  TIMEOUT  64   cycles to wait for tx_busy to rise (used only with UART_SCHED_TIMEOUT_EN)
// PORTS
//  clk           in   1                 system clock; every tx_busy input is already synchronous to it
//  rst           in   1                 synchronous, active-high reset
//  req           in   NUM_REQ           level request per requester, held until its req_ack
//  req_two_byte  in   NUM_REQ           1: frame is 2 bytes; 0: frame is 1 byte (low byte only)
//  req_data      in   NUM_REQ*2*WIDTH   requester i owns bits [i*2*WIDTH +: 2*WIDTH]
//  req_ack       out  NUM_REQ           one-cycle pulse to the granted requester at frame end
//  tx_p_data     out  WIDTH             byte to the transmitter (drives TX_P_DATA)
//  tx_d_vld      out  1                 one-cycle byte strobe (drives TX_D_VLD)
//  tx_busy       in   1                 transmitter Busy
//  sched_busy    out  1                 high in every state except IDLE
//  grant_id      out  ID_W              index of the current/last granted requester
//  timeout_err   out  1                 one-cycle pulse on abort by timeout (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; tx_d_vld=0, tx_p_data=0, req_ack=0, timeout_err=0, sched_busy=0,
//   grant_id=0; rr pointer last=NUM_REQ-1, so requester 0 has top priority. Reset mid-frame
//   aborts the frame with no ack; the requester keeps req asserted and is re-arbitrated.
//  States: IDLE, LOAD, WAIT_HI, WAIT_LO, DONE.
//  IDLE: if |req, grant the first set bit searching last+1, last+2, ... (mod NUM_REQ).
//   At that edge: capture the 2*WIDTH data and the two_byte bit into holding registers,
//   set grant_id, set byte_sel=0, set last=grant, go to LOAD. req is sampled only in IDLE.
//  LOAD: tx_d_vld=1 for exactly this cycle; tx_p_data = byte_sel ? hold[2W-1:W] : hold[W-1:0].
//   Byte order is low byte first. Always go to WAIT_HI.
//  tx_p_data is registered and stays stable from LOAD until the next LOAD or IDLE.
//  WAIT_HI: stay until tx_busy=1, then go to WAIT_LO. A tx_busy already high in the LOAD
//   cycle does not count; only samples taken in WAIT_HI count.
//  WAIT_LO: stay until tx_busy=0. Then, if two_byte && byte_sel==0: set byte_sel=1 and go to
//   LOAD. Otherwise go to DONE.
//  DONE: req_ack[grant_id]=1 for one cycle, then go to IDLE. A requester clears req on the
//   ack edge, so IDLE never sees a stale request.
//  Latency: req high in IDLE at cycle n gives tx_d_vld=1 at cycle n+1. Back-to-back frames
//   are separated by DONE plus IDLE (2 cycles) after the final busy fall.
//  New or dropped req bits during a frame have no effect until the next IDLE.
//  The holding registers isolate the frame from changes to req_data after the grant.
//  The rr pointer advances only on a grant.
//  The wrap from NUM_REQ-1 to 0 is correct for non-power-of-2 NUM_REQ.
// CONFIGURATION
//  UART_SCHED_TIMEOUT_EN defined: an 8-bit-or-wider counter clears on entry to WAIT_HI and
//   counts while in WAIT_HI. When it reaches TIMEOUT-1 with tx_busy still 0, the frame is
//   aborted: timeout_err pulses 1 cycle and the state goes to DONE, so the requester is still
//   acked and the bus cannot lock up. WAIT_LO is never timed.
//  Macro not defined: no counter is built; WAIT_HI waits indefinitely; timeout_err is
//   constant 0.
// TESTING
//  1. After reset, req=4'b0001, two_byte=0, data[7:0]=8'hA5; busy goes high 3 cycles after
//     the strobe and low 10 cycles after that -> tx_d_vld one cycle, tx_p_data=A5,
//     req_ack[0] one pulse, sched_busy back to 0.
//  2. req0 two_byte, data=16'hBEEF -> two strobes, bytes EF then BE, each strobe only after
//     the previous busy fall; exactly one ack.
//  3. req=4'b1111 held (each requester re-requests after its ack) -> grant order
//     0,1,2,3,0,...; no requester is granted twice in a row.
//  4. rst asserted during WAIT_LO of a 2-byte frame -> all outputs return to reset values
//     next cycle, no ack, and the frame restarts from the low byte.
//  5. Macro on, TIMEOUT=64, tx_busy held 0 -> timeout_err and req_ack pulse 64 cycles after
//     WAIT_HI entry, then the next requester is served. Macro off, same stimulus -> the
//     scheduler stays in WAIT_HI and timeout_err stays 0.
//  6. req_data changed the cycle after the grant -> the transmitted byte equals the value
//     captured at the grant.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART transmitter between NUM_REQ
// requesters, sending each granted 1- or 2-byte frame as single-byte strobes, low byte first.
// Optional build macro: UART_SCHED_TIMEOUT_EN (abort a byte whose tx_busy never rises).
module uart_tx_scheduler #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_two_byte,
    input  logic [NUM_REQ*2*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [WIDTH-1:0]             tx_p_data,
    output logic                         tx_d_vld,
    input  logic                         tx_busy,
    output logic                         sched_busy,
    output logic [ID_W-1:0]              grant_id,
    output logic                         timeout_err
);

    localparam int unsigned FRAME_W = 2 * WIDTH;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("uart_tx_scheduler: NUM_REQ must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_tx_scheduler: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   hold_q, hold_d;
    logic                 two_q, two_d;
    logic                 sel_q, sel_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      gid_q, gid_d;
    logic                 vld_q, vld_d;
    logic [WIDTH-1:0]     pdata_q, pdata_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 sbusy_q, sbusy_d;
    logic                 terr_q, terr_d;

    logic                 found_c;
    logic [ID_W-1:0]      pick_c;
    logic [FRAME_W-1:0]   pick_data_c;
    logic                 pick_two_c;
    logic                 timeout_hit_c;

    // Round-robin search starting just after the last granted requester, with explicit wrap.
    always_comb begin
        int unsigned idx;
        found_c = 1'b0;
        pick_c  = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found_c && req[ID_W'(idx)]) begin
                found_c = 1'b1;
                pick_c  = ID_W'(idx);
            end
        end
    end

    // Select the winner's frame payload and length flag.
    always_comb begin
        pick_data_c = '0;
        pick_two_c  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_c == ID_W'(i)) begin
                pick_data_c = req_data[i*FRAME_W +: FRAME_W];
                pick_two_c  = req_two_byte[i];
            end
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count cycles spent in WAIT_HI; zero in every other state so entry starts from 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT_HI) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit_c = (state_q == WAIT_HI) && !tx_busy && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        two_d   = two_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gid_d   = gid_q;

        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    hold_d  = pick_data_c;
                    two_d   = pick_two_c;
                    sel_d   = 1'b0;
                    gid_d   = pick_c;
                    last_d  = pick_c;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (timeout_hit_c) begin
                    state_d = DONE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (two_q && !sel_q) begin
                        sel_d   = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vld_d   = (state_d == LOAD);
        pdata_d = pdata_q;
        if (state_d == LOAD) begin
            pdata_d = sel_d ? hold_d[FRAME_W-1:WIDTH] : hold_d[WIDTH-1:0];
        end
        ack_d   = (state_d == DONE) ? (NUM_REQ'(1) << gid_d) : '0;
        sbusy_d = (state_d != IDLE);
        terr_d  = timeout_hit_c;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            two_q   <= 1'b0;
            sel_q   <= 1'b0;
            last_q  <= ID_W'(NUM_REQ - 1);
            gid_q   <= '0;
            vld_q   <= 1'b0;
            pdata_q <= '0;
            ack_q   <= '0;
            sbusy_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            two_q   <= two_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            vld_q   <= vld_d;
            pdata_q <= pdata_d;
            ack_q   <= ack_d;
            sbusy_q <= sbusy_d;
            terr_q  <= terr_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_p_data   = pdata_q;
    assign tx_d_vld    = vld_q;
    assign sched_busy  = sbusy_q;
    assign grant_id    = gid_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and randomized checks of uart_tx_scheduler against a
// frame-level reference model (arbitration rule, byte order, busy handshake timing).
// Honours UART_SCHED_TIMEOUT_EN when the bench is built with the same macro as the RTL.
module tb_uart_tx_scheduler;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          req_two_byte;
    logic [NUM_REQ*2*WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]          req_ack;
    logic [WIDTH-1:0]            tx_p_data;
    logic                        tx_d_vld;
    logic                        tx_busy;
    logic                        sched_busy;
    logic [ID_W-1:0]             grant_id;
    logic                        timeout_err;

    uart_tx_scheduler #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_two_byte (req_two_byte),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .tx_p_data    (tx_p_data),
        .tx_d_vld     (tx_d_vld),
        .tx_busy      (tx_busy),
        .sched_busy   (sched_busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (frame level).
    logic        in_frame;
    int          exp_id;
    int          exp_gid;
    int          exp_bytes;
    int          sent;
    logic [15:0] hold;
    int          last;
    logic        prev_idle;
    int          since;
    logic        hi_seen;
    logic        fell;
    int          n_to;

    // Transmitter and requester behaviour controls.
    logic        auto_busy;
    logic        rnd_busy;
    int          rise_d;
    int          hi_d;
    int          rise_cnt;
    int          hi_cnt;
    int          rereq_mode;
    logic [NUM_REQ-1:0] rereq_mask;
    logic        scramble;

    logic [7:0]  bytes[$];
    int          grants[$];
    int          acks[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample DUT, compare against the model, then drive inputs for the next cycle.
    task automatic tick();
        logic [NUM_REQ-1:0]         s_req;
        logic [NUM_REQ*2*WIDTH-1:0] s_data;
        logic [NUM_REQ-1:0]         s_two;
        logic                       s_rst;
        logic                       s_busy;
        logic                       fell_now;
        logic                       to_now;
        logic                       exp_vld;
        logic [NUM_REQ-1:0]         exp_ack;
        int                         ack_id;
        @(posedge clk);
        #1;
        s_req    = req;
        s_data   = req_data;
        s_two    = req_two_byte;
        s_rst    = rst;
        s_busy   = tx_busy;
        fell_now = 1'b0;
        to_now   = 1'b0;
        exp_vld  = 1'b0;
        exp_ack  = '0;
        ack_id   = -1;
        if (s_rst) begin
            check_eq("rst_tx_d_vld",    32'(tx_d_vld),    0);
            check_eq("rst_tx_p_data",   32'(tx_p_data),   0);
            check_eq("rst_req_ack",     32'(req_ack),     0);
            check_eq("rst_timeout_err", 32'(timeout_err), 0);
            check_eq("rst_sched_busy",  32'(sched_busy),  0);
            check_eq("rst_grant_id",    32'(grant_id),    0);
            in_frame  = 1'b0;
            last      = NUM_REQ - 1;
            exp_gid   = 0;
            prev_idle = 1'b1;
            tx_busy   = 1'b0;
            rise_cnt  = 0;
            hi_cnt    = 0;
        end else begin
            if (in_frame) begin
                since++;
                if (since >= 2 && !fell) begin
                    if (s_busy) begin
                        hi_seen = 1'b1;
                    end else if (hi_seen) begin
                        fell     = 1'b1;
                        fell_now = 1'b1;
                    end
                end
`ifdef UART_SCHED_TIMEOUT_EN
                if (!hi_seen && since == TIMEOUT + 1) begin
                    to_now = 1'b1;
                end
`endif
                if (to_now || (fell_now && sent == exp_bytes)) begin
                    exp_ack = NUM_REQ'(1) << exp_id;
                    ack_id  = exp_id;
                end else if (fell_now) begin
                    exp_vld = 1'b1;
                end
            end else begin
                exp_vld = prev_idle && (s_req != '0);
            end
            check_eq("tx_d_vld",    32'(tx_d_vld),    32'(exp_vld));
            check_eq("req_ack",     32'(req_ack),     32'(exp_ack));
            check_eq("timeout_err", 32'(timeout_err), 32'(to_now));
            if (exp_vld) begin
                if (!in_frame) begin
                    exp_id = -1;
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        int i;
                        i = (last + k) % NUM_REQ;
                        if (exp_id < 0 && s_req[i]) begin
                            exp_id = i;
                        end
                    end
                    hold      = s_data[exp_id*16 +: 16];
                    exp_bytes = s_two[exp_id] ? 2 : 1;
                    sent      = 0;
                    in_frame  = 1'b1;
                    last      = exp_id;
                    exp_gid   = exp_id;
                    grants.push_back(exp_id);
                end
                check_eq("tx_p_data", 32'(tx_p_data), 32'(sent == 0 ? hold[7:0] : hold[15:8]));
                bytes.push_back(tx_p_data);
                sent++;
                since   = 0;
                hi_seen = 1'b0;
                fell    = 1'b0;
            end
            check_eq("grant_id",   32'(grant_id),   32'(exp_gid));
            check_eq("sched_busy", 32'(sched_busy), 32'(in_frame));
            if (exp_ack != '0) begin
                in_frame = 1'b0;
                acks.push_back(exp_id);
                if (to_now) n_to++;
            end
            prev_idle = !in_frame && (exp_ack == '0);
            // Transmitter: busy rises rise_d cycles after a strobe and stays high hi_d cycles.
            if (auto_busy) begin
                if (tx_d_vld) begin
                    rise_cnt = rnd_busy ? int'($urandom_range(1, 4)) : rise_d;
                    hi_cnt   = 0;
                end else if (rise_cnt > 0) begin
                    rise_cnt--;
                    if (rise_cnt == 0) begin
                        tx_busy = 1'b1;
                        hi_cnt  = rnd_busy ? int'($urandom_range(1, 6)) : hi_d;
                    end
                end else if (hi_cnt > 0) begin
                    hi_cnt--;
                    if (hi_cnt == 0) tx_busy = 1'b0;
                end
            end
        end
        // Requesters: drop req on the ack, optionally re-request later.
        req        = req | rereq_mask;
        rereq_mask = '0;
        if (ack_id >= 0) begin
            req[ack_id] = 1'b0;
            if (rereq_mode == 1) rereq_mask[ack_id] = 1'b1;
        end
        if (rereq_mode == 2) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && i != ack_id && $urandom_range(0, 3) == 0) begin
                    req[i]             = 1'b1;
                    req_two_byte[i]    = 1'($urandom_range(0, 1));
                    req_data[i*16 +: 16] = 16'($urandom);
                end
            end
        end
        if (scramble && tx_d_vld) begin
            req_data = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        rereq_mode = 0;
        req        = '0;
        rereq_mask = '0;
        rst        = 1'b1;
        tick();
        tick();
        rst        = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (acks.size() < n && c < budget) begin
            tick();
            c++;
        end
        check_eq(tag, 32'(acks.size()), 32'(n));
    endtask

    task automatic clear_logs();
        bytes.delete();
        grants.delete();
        acks.delete();
        n_to = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req          = '0;
        req_two_byte = '0;
        req_data     = '0;
        tx_busy      = 1'b0;
        in_frame     = 1'b0;
        exp_id       = 0;
        exp_gid      = 0;
        exp_bytes    = 1;
        sent         = 0;
        hold         = '0;
        last         = NUM_REQ - 1;
        prev_idle    = 1'b1;
        since        = 0;
        hi_seen      = 1'b0;
        fell         = 1'b0;
        n_to         = 0;
        auto_busy    = 1'b1;
        rnd_busy     = 1'b0;
        rise_d       = 3;
        hi_d         = 10;
        rise_cnt     = 0;
        hi_cnt       = 0;
        rereq_mode   = 0;
        rereq_mask   = '0;
        scramble     = 1'b1;

        // Single-byte frame, data changed right after the grant.
        do_reset();
        clear_logs();
        req_data[7:0] = 8'hA5;
        req           = 4'b0001;
        wait_acks(1, 100, "t1_ack_count");
        repeat (3) tick();
        check_eq("t1_byte_count", 32'(bytes.size()), 1);
        check_eq("t1_byte",       32'(bytes[0]),     32'h A5);
        check_eq("t1_grant",      32'(grants[0]),    0);

        // Two-byte frame, low byte first.
        clear_logs();
        req_data[15:0]  = 16'hBEEF;
        req_two_byte[0] = 1'b1;
        req             = 4'b0001;
        wait_acks(1, 100, "t2_ack_count");
        repeat (3) tick();
        check_eq("t2_byte_count", 32'(bytes.size()), 2);
        check_eq("t2_byte_lo",    32'(bytes[0]),     32'h EF);
        check_eq("t2_byte_hi",    32'(bytes[1]),     32'h BE);

        // All requesters held: strict rotation 0,1,2,3,0,1.
        do_reset();
        clear_logs();
        rise_d       = 1;
        hi_d         = 2;
        req_two_byte = '0;
        req          = 4'b1111;
        rereq_mode   = 1;
        wait_acks(6, 200, "t3_ack_count");
        for (int k = 0; k < 6; k++) begin
            check_eq("t3_grant_order", 32'(grants[k]), 32'(k % NUM_REQ));
        end

        // Reset during WAIT_LO of a two-byte frame restarts from the low byte.
        do_reset();
        clear_logs();
        scramble        = 1'b0;
        rise_d          = 2;
        hi_d            = 8;
        req_data[15:0]  = 16'h1234;
        req_two_byte[0] = 1'b1;
        req             = 4'b0001;
        for (int c = 0; c < 50 && !(in_frame && sent == 1 && hi_seen); c++) tick();
        check_eq("t4_reached_wait_lo", 32'(tx_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_acks(1, 100, "t4_ack_count");
        check_eq("t4_byte_count", 32'(bytes.size()), 3);
        check_eq("t4_byte0",      32'(bytes[0]),     32'h 34);
        check_eq("t4_byte1",      32'(bytes[1]),     32'h 34);
        check_eq("t4_byte2",      32'(bytes[2]),     32'h 12);
        scramble = 1'b1;

        // Transmitter never goes busy.
        do_reset();
        clear_logs();
        auto_busy    = 1'b0;
        tx_busy      = 1'b0;
        req_two_byte = '0;
        req          = 4'b0011;
        repeat (150) tick();
`ifdef UART_SCHED_TIMEOUT_EN
        check_eq("t5_acks",     32'(acks.size() >= 2), 1);
        check_eq("t5_ack0",     32'(acks[0]),          0);
        check_eq("t5_grant1",   32'(grants[1]),        1);
        check_eq("t5_timeouts", 32'(n_to >= 2),        1);
`else
        check_eq("t5_no_ack",   32'(acks.size()),   0);
        check_eq("t5_grants",   32'(grants.size()), 1);
        check_eq("t5_stuck",    32'(sched_busy),    1);
`endif
        auto_busy = 1'b1;

        // Randomized traffic with random busy timing and request arrivals.
        do_reset();
        clear_logs();
        rnd_busy   = 1'b1;
        rereq_mode = 2;
        repeat (3000) tick();
        rereq_mode = 0;
        for (int c = 0; c < 2000 && (req != '0 || in_frame); c++) tick();
        check_eq("rand_drained", 32'(req != '0 || in_frame), 0);
        check_eq("rand_enough_frames", 32'(acks.size() > 50), 1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
